sdram_result_writer: RTL and testbench
======================================

Name: sdram_result_writer

Overview:
Write-side initiator on the External Bridge to Avalon Master interface, the counterpart to sdram_reader's read path. It accepts 32-bit classifier result entries from the fp_mac side (for example {28'b0, index_pred} or result_fp) through a valid/ready handshake, and packs four entries into each 128-bit bridge word. Each word is written to a circular SDRAM results region, and a flush writes a partial word using byte-enable masking.

Parameters:
INTERFACE_WIDTH_BITS, 128, bridge data width; fixed at 4 entries per word.
INTERFACE_ADDR_BITS, 26, bridge byte-address width.
BASE_ADDR, 26'h0200000, byte address of the first word of the results region; 16-byte aligned.
NUM_WORDS, 64, region size in 128-bit words; range 2..65535.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  entry on in_data is valid.
in_data  in  32  result entry.
in_ready  out  1  entry accepted on an edge where in_valid && in_ready.
flush  in  1  single-cycle request to write any buffered partial word.
interface_address  out  INTERFACE_ADDR_BITS  byte address of the current write.
interface_byte_enable  out  INTERFACE_WIDTH_BITS/8  per-byte write enable.
interface_write  out  1  write request; held until acknowledged.
interface_write_data  out  INTERFACE_WIDTH_BITS  packed word.
interface_acknowledge  in  1  bridge completion strobe.
busy  out  1  high in WRITE or when lane_cnt != 0.
wrapped  out  1  one-cycle pulse when the address wraps to BASE_ADDR.
words_written  out  16  count of completed writes; wraps at 65535 -> 0.

Behaviour:
- Reset values:
  - state=FILL, lane_cnt=0, word_idx=0.
  - interface_address=BASE_ADDR, interface_byte_enable=0, interface_write=0, interface_write_data=0.
  - in_ready=0 during reset, then 1 in FILL.
  - busy=0, wrapped=0, words_written=0.
- Packing:
  - Entry k (0..3) occupies data[32k+31:32k] and byte_enable[4k+3:4k].
  - Unfilled lanes carry data 0 and enable 0.
- Address: interface_address = BASE_ADDR + 16*word_idx.
- FILL state:
  - in_ready=1, interface_write=0.
  - Each accepted entry is stored in lane lane_cnt, and lane_cnt increments.
  - When the 4th entry is accepted (lane_cnt 3->4) at edge N, the state is WRITE from cycle N+1 with byte_enable=16'hFFFF.
  - When flush is sampled with lane_cnt>0, WRITE is entered next cycle with a partial enable mask.
  - flush with lane_cnt=0 and no entry accepted is ignored; no write occurs.
  - flush on the same edge as an entry accept: the entry is included, then WRITE. If that entry was the 4th, exactly one full write occurs and the flush is consumed.
- WRITE state:
  - in_ready=0, interface_write=1.
  - Address, data and byte_enable are stable until ack; flush is ignored.
  - An edge with interface_write && interface_acknowledge completes the write:
    - interface_write=0 next cycle;
    - lane buffers and byte_enable clear, lane_cnt=0;
    - words_written+1;
    - word_idx+1, or 0 if word_idx==NUM_WORDS-1, in which case wrapped=1 for one cycle;
    - return to FILL.
  - Ack may arrive on the first cycle of WRITE. Minimum cycle from the first accept of a word to the first accept of the next: 4 accepts + 1 WRITE cycle.
- interface_acknowledge outside WRITE is ignored.
- in_data is not captured when in_ready=0; upstream holds the entry until in_ready.
- Reset mid-WRITE: interface_write=0 on the reset edge; buffered entries are discarded and word_idx returns to 0. The system reset path is responsible for quiescing the bridge.
- No combinational path from inputs to outputs.

Test Plan:
1. Full-word write:
   - Stimulus: after reset, send entries 32'h11111111, 22222222, 33333333, 44444444 back-to-back; ack 3 cycles after interface_write rises.
   - Required: interface_write_data=128'h44444444_33333333_22222222_11111111, byte_enable=FFFF, address=26'h0200000, all held for 3 cycles.
   - Then: words_written=1, next address 26'h0200010.
2. Partial flush:
   - Stimulus: send two entries A, B, then flush.
   - Required: write data {64'h0, B, A}, byte_enable=16'h00FF, in_ready=0 until ack.
   - Stimulus: flush with an empty buffer. Required: no interface_write.
3. Simultaneous flush and last entry:
   - Stimulus: assert flush on the same edge as the 4th entry accept.
   - Required: exactly one write with FFFF; no second write; words_written increments by 1.
   - Stimulus: flush with the 2nd entry. Required: byte_enable=00FF.
4. Wrap-around:
   - Stimulus: NUM_WORDS=2, write 3 full words.
   - Required: addresses 0200000, 0200010, 0200000; wrapped pulses for one cycle after the 2nd ack.
5. Backpressure and stray ack:
   - Stimulus: hold in_valid during WRITE; pulse ack during FILL.
   - Required: no entry lost or duplicated, lane_cnt unchanged by the stray ack, words_written unchanged.
6. Reset mid-write:
   - Stimulus: assert reset while interface_write=1.
   - Required: all outputs at reset values on the next edge; the next word is written to BASE_ADDR with only newly sent data.

Source files
------------

// File: rtl/sdram_result_writer_if.sv
// Bundle of the result-entry stream and the bridge write channel used by
// sdram_result_writer. The master side is the writer, the slave side is the
// combined upstream producer and bridge.
interface sdram_result_writer_if #(
   parameter int INTERFACE_WIDTH_BITS = 128,
   parameter int INTERFACE_ADDR_BITS  = 26
);
   // Upstream entry stream
   logic                                in_valid;
   logic [31:0]                         in_data;
   logic                                in_ready;
   logic                                flush;
   // Bridge write channel
   logic [INTERFACE_ADDR_BITS-1:0]      interface_address;
   logic [INTERFACE_WIDTH_BITS/8-1:0]   interface_byte_enable;
   logic                                interface_write;
   logic [INTERFACE_WIDTH_BITS-1:0]     interface_write_data;
   logic                                interface_acknowledge;

   modport master (
      input  in_valid, in_data, flush, interface_acknowledge,
      output in_ready, interface_address, interface_byte_enable,
             interface_write, interface_write_data
   );

   modport slave (
      output in_valid, in_data, flush, interface_acknowledge,
      input  in_ready, interface_address, interface_byte_enable,
             interface_write, interface_write_data
   );
endinterface

// File: rtl/sdram_result_writer.sv
// Packs 32-bit classifier result entries four to a 128-bit bridge word and
// writes each word into a circular SDRAM results region. A flush pushes out a
// partially filled word with only the filled lanes byte-enabled.
module sdram_result_writer #(
   parameter int                               INTERFACE_WIDTH_BITS = 128,
   parameter int                               INTERFACE_ADDR_BITS  = 26,
   parameter logic [INTERFACE_ADDR_BITS-1:0]   BASE_ADDR            = 'h0200000,
   parameter int                               NUM_WORDS            = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   sdram_result_writer_if.master bus,
   output logic                 busy,
   output logic                 wrapped,
   output logic [15:0]          words_written
);

   localparam int BE_W = INTERFACE_WIDTH_BITS / 8;

   localparam logic [0:0] S_FILL  = 1'b0;
   localparam logic [0:0] S_WRITE = 1'b1;

   logic [0:0]                       state;
   logic [2:0]                       lane_cnt;
   logic [15:0]                      word_idx;
   logic [INTERFACE_ADDR_BITS-1:0]   addr_q;
   logic [BE_W-1:0]                  be_q;
   logic [INTERFACE_WIDTH_BITS-1:0]  data_q;
   logic                             ready_q;

   logic accept;
   logic last_lane;
   logic go_write;
   logic done;
   logic at_last_word;

   // Handshake decode; in_ready is registered so no input reaches an output combinationally
   always_comb begin
      accept       = bus.in_valid && ready_q;
      last_lane    = accept && (lane_cnt == 3'd3);
      go_write     = last_lane || (bus.flush && ((lane_cnt != 3'd0) || accept));
      done         = (state == S_WRITE) && bus.interface_acknowledge;
      at_last_word = (word_idx == 16'(NUM_WORDS - 1));
   end

   // Fill/write sequencing, lane packing, region address and completion counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FILL;
         lane_cnt      <= 3'd0;
         word_idx      <= 16'd0;
         addr_q        <= BASE_ADDR;
         be_q          <= '0;
         data_q        <= '0;
         ready_q       <= 1'b0;
         wrapped       <= 1'b0;
         words_written <= 16'd0;
      end else begin
         wrapped <= 1'b0;
         case (state)
            S_FILL: begin
               ready_q <= 1'b1;
               if (accept) begin
                  data_q[32*lane_cnt[1:0] +: 32] <= bus.in_data;
                  be_q[4*lane_cnt[1:0] +: 4]     <= 4'hF;
                  lane_cnt                       <= lane_cnt + 3'd1;
               end
               // A flush on the same edge as the fourth entry folds into the full write
               if (go_write) begin
                  state   <= S_WRITE;
                  ready_q <= 1'b0;
               end
            end
            S_WRITE: begin
               if (done) begin
                  state         <= S_FILL;
                  ready_q       <= 1'b1;
                  lane_cnt      <= 3'd0;
                  be_q          <= '0;
                  data_q        <= '0;
                  words_written <= words_written + 16'd1;
                  if (at_last_word) begin
                     word_idx <= 16'd0;
                     addr_q   <= BASE_ADDR;
                     wrapped  <= 1'b1;
                  end else begin
                     word_idx <= word_idx + 16'd1;
                     addr_q   <= addr_q + INTERFACE_ADDR_BITS'(16);
                  end
               end
            end
            default: begin
               state   <= S_FILL;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs are decoded from registered state only
   always_comb begin
      bus.in_ready              = ready_q;
      bus.interface_write       = (state == S_WRITE);
      bus.interface_address     = addr_q;
      bus.interface_byte_enable = be_q;
      bus.interface_write_data  = data_q;
      busy                      = (state == S_WRITE) || (lane_cnt != 3'd0);
   end

endmodule

// File: tb/tb_sdram_result_writer.sv
// Scoreboard bench for sdram_result_writer: directed entries push expected
// bridge words into a queue, a negedge monitor pops them on each completed
// write and tracks words_written and the wrap pulse with its own model.
module tb_sdram_result_writer;

   localparam int NW = 2;

   typedef struct packed {
      logic [25:0]  addr;
      logic [127:0] data;
      logic [15:0]  be;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        busy;
   logic        wrapped;
   logic [15:0] words_written;

   sdram_result_writer_if #(.INTERFACE_WIDTH_BITS(128), .INTERFACE_ADDR_BITS(26)) bus ();

   sdram_result_writer #(
      .INTERFACE_WIDTH_BITS(128),
      .INTERFACE_ADDR_BITS (26),
      .BASE_ADDR           (26'h0200000),
      .NUM_WORDS           (NW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .busy         (busy),
      .wrapped      (wrapped),
      .words_written(words_written)
   );

   int total = 0;
   int bad   = 0;

   wr_t exp_q[$];

   int  ack_delay = 2;
   bit  ack_en    = 1'b1;
   int  wcnt      = 0;

   // monitor model
   logic [15:0]  exp_words    = 16'd0;
   int           exp_idx      = 0;
   bit           wrap_pending = 1'b0;
   bit           prev_write   = 1'b0;
   logic [25:0]  prev_addr;
   logic [127:0] prev_data;
   logic [15:0]  prev_be;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Bridge model: acknowledge ack_delay+1 cycles after interface_write rises
   always @(posedge clk) begin
      #1;
      if (bus.interface_write && ack_en && !bus.interface_acknowledge) begin
         if (wcnt >= ack_delay) bus.interface_acknowledge = 1'b1;
         else wcnt++;
      end else begin
         bus.interface_acknowledge = 1'b0;
         wcnt = 0;
      end
   end

   // Monitor: compare completed writes against the scoreboard and track counters
   always @(negedge clk) begin
      wr_t e;
      chk("wrapped", {127'b0, wrapped}, {127'b0, wrap_pending});
      chk("words_written", {112'b0, words_written}, {112'b0, exp_words});
      if (bus.interface_write) begin
         chk("in_ready_in_write", {127'b0, bus.in_ready}, 128'd0);
         if (prev_write) begin
            chk("hold_addr", {102'b0, bus.interface_address}, {102'b0, prev_addr});
            chk("hold_data", bus.interface_write_data, prev_data);
            chk("hold_be", {112'b0, bus.interface_byte_enable}, {112'b0, prev_be});
         end
      end
      if (reset) begin
         exp_words    = 16'd0;
         exp_idx      = 0;
         wrap_pending = 1'b0;
         prev_write   = 1'b0;
      end else begin
         wrap_pending = 1'b0;
         if (bus.interface_write && bus.interface_acknowledge) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write addr=%0h data=%0h be=%0h",
                        bus.interface_address, bus.interface_write_data, bus.interface_byte_enable);
            end else begin
               e = exp_q.pop_front();
               if (bus.interface_address !== e.addr || bus.interface_write_data !== e.data ||
                   bus.interface_byte_enable !== e.be) begin
                  bad++;
                  $display("FAIL write_word actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                           bus.interface_address, bus.interface_write_data, bus.interface_byte_enable,
                           e.addr, e.data, e.be);
               end
            end
            exp_words    = exp_words + 16'd1;
            wrap_pending = (exp_idx == NW - 1);
            exp_idx      = (exp_idx == NW - 1) ? 0 : exp_idx + 1;
            prev_write   = 1'b0;
         end else begin
            prev_write = bus.interface_write;
            prev_addr  = bus.interface_address;
            prev_data  = bus.interface_write_data;
            prev_be    = bus.interface_byte_enable;
         end
      end
   end

   // All stimulus tasks run in the posedge+1 phase
   task automatic send(input logic [31:0] d, input logic f);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.flush    = f;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=%0d required=1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
   endtask

   task automatic send4(input logic [31:0] b);
      for (int k = 1; k <= 4; k++) send(b | 32'(k), 1'b0);
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
   endtask

   task automatic wait_words(input logic [15:0] n);
      int k = 0;
      while (words_written != n && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("wait_words", {112'b0, words_written}, {112'b0, n});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [25:0] a, input logic [127:0] d, input logic [15:0] be);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.be   = be;
      exp_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'd0;
      bus.flush    = 1'b0;
      bus.interface_acknowledge = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // reset values
      chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
      chk("rst_write", {127'b0, bus.interface_write}, 128'd0);
      chk("rst_addr", {102'b0, bus.interface_address}, {102'b0, 26'h0200000});
      chk("rst_be", {112'b0, bus.interface_byte_enable}, 128'd0);
      chk("rst_data", bus.interface_write_data, 128'd0);
      chk("rst_busy", {127'b0, busy}, 128'd0);
      reset = 1'b0;
      idle(1);
      chk("ready_after_rst", {127'b0, bus.in_ready}, 128'd1);

      // 1: full word
      push(26'h0200000, 128'h44444444_33333333_22222222_11111111, 16'hFFFF);
      send(32'h11111111, 1'b0);
      send(32'h22222222, 1'b0);
      send(32'h33333333, 1'b0);
      send(32'h44444444, 1'b0);
      chk("t1_write_up", {127'b0, bus.interface_write}, 128'd1);
      chk("t1_busy", {127'b0, busy}, 128'd1);
      wait_words(16'd1);
      chk("t1_next_addr", {102'b0, bus.interface_address}, {102'b0, 26'h0200010});
      chk("t1_idle_busy", {127'b0, busy}, 128'd0);

      // 2: partial flush, then empty flush
      push(26'h0200010, {64'h0, 32'hB1B2B3B4, 32'hA1A2A3A4}, 16'h00FF);
      send(32'hA1A2A3A4, 1'b0);
      send(32'hB1B2B3B4, 1'b0);
      chk("t2_busy_partial", {127'b0, busy}, 128'd1);
      do_flush();
      chk("t2_write_up", {127'b0, bus.interface_write}, 128'd1);
      wait_words(16'd2);
      chk("t2_wrap_addr", {102'b0, bus.interface_address}, {102'b0, 26'h0200000});
      do_flush();
      for (int i = 0; i < 5; i++) begin
         chk("t2_empty_flush_no_write", {127'b0, bus.interface_write}, 128'd0);
         idle(1);
      end
      chk("t2_words_after_empty", {112'b0, words_written}, {112'b0, 16'd2});

      // 3: flush with 4th entry, then flush with 2nd entry
      push(26'h0200000, 128'hC0000004_C0000003_C0000002_C0000001, 16'hFFFF);
      send(32'hC0000001, 1'b0);
      send(32'hC0000002, 1'b0);
      send(32'hC0000003, 1'b0);
      send(32'hC0000004, 1'b1);
      wait_words(16'd3);
      for (int i = 0; i < 5; i++) begin
         chk("t3_no_second_write", {127'b0, bus.interface_write}, 128'd0);
         idle(1);
      end
      chk("t3_words", {112'b0, words_written}, {112'b0, 16'd3});
      push(26'h0200010, {64'h0, 32'hD0000002, 32'hD0000001}, 16'h00FF);
      send(32'hD0000001, 1'b0);
      send(32'hD0000002, 1'b1);
      wait_words(16'd4);

      // 4: wrap-around over three full words
      push(26'h0200000, 128'hE0000004_E0000003_E0000002_E0000001, 16'hFFFF);
      push(26'h0200010, 128'hE1000004_E1000003_E1000002_E1000001, 16'hFFFF);
      push(26'h0200000, 128'hE2000004_E2000003_E2000002_E2000001, 16'hFFFF);
      send4(32'hE0000000);
      send4(32'hE1000000);
      send4(32'hE2000000);
      wait_words(16'd7);

      // 5: backpressure with in_valid held through WRITE, then a stray ack in FILL
      ack_delay = 4;
      push(26'h0200010, 128'hF0000004_F0000003_F0000002_F0000001, 16'hFFFF);
      push(26'h0200000, 128'hF1000004_F1000003_F1000002_F1000001, 16'hFFFF);
      send4(32'hF0000000);
      send4(32'hF1000000);
      wait_words(16'd9);
      ack_delay = 2;
      push(26'h0200010, 128'h90000004_90000003_90000002_90000001, 16'hFFFF);
      send(32'h90000001, 1'b0);
      send(32'h90000002, 1'b0);
      @(negedge clk);
      bus.interface_acknowledge = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_stray_no_write", {127'b0, bus.interface_write}, 128'd0);
      chk("t5_stray_busy", {127'b0, busy}, 128'd1);
      chk("t5_stray_words", {112'b0, words_written}, {112'b0, 16'd9});
      send(32'h90000003, 1'b0);
      send(32'h90000004, 1'b0);
      wait_words(16'd10);

      // 6: reset while a write is pending
      ack_en = 1'b0;
      send4(32'h70000000);
      chk("t6_write_pending", {127'b0, bus.interface_write}, 128'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t6_write", {127'b0, bus.interface_write}, 128'd0);
      chk("t6_addr", {102'b0, bus.interface_address}, {102'b0, 26'h0200000});
      chk("t6_be", {112'b0, bus.interface_byte_enable}, 128'd0);
      chk("t6_data", bus.interface_write_data, 128'd0);
      chk("t6_in_ready", {127'b0, bus.in_ready}, 128'd0);
      chk("t6_busy", {127'b0, busy}, 128'd0);
      chk("t6_words", {112'b0, words_written}, 128'd0);
      ack_en = 1'b1;
      push(26'h0200000, 128'h80000004_80000003_80000002_80000001, 16'hFFFF);
      send4(32'h80000000);
      wait_words(16'd1);
      chk("t6_next_addr", {102'b0, bus.interface_address}, {102'b0, 26'h0200010});
      idle(3);
      chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
